out_stream_ctrl: RTL

Readout controller that sits directly downstream of the 4x4 array's output memory (`DATAMEM_output`). On a start pulse it walks a contiguous address range of that memory through its asynchronous read port (`addr_out`/`data_out`). It streams each 16-bit result word to a host/DMA consumer over a valid/ready handshake, flags the final word, and pulses `done`. A 4x4 tile occupies 16 consecutive words in column-major order (C11, C21, C31, C41, C12, …), and is streamed in that order.

---
 rtl/out_stream_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/out_stream_ctrl.sv
// Readout streamer for the array output memory: walks base..base+count-1 (mod MEM_DEPTH)
// and presents each word on a valid/ready stream. Define OUT_STREAM_RELU_EN to clamp negative words to zero.
module out_stream_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [8:0]        word_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [8:0]        idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              zwait_q, zwait_d;
  logic              load_en;
  logic              is_last_idx;
  logic [ADDR_W-1:0] addr_sum;

  function automatic logic [DATA_W-1:0] load_fn(input logic signed [DATA_W-1:0] x);
`ifdef OUT_STREAM_RELU_EN
    load_fn = x[DATA_W-1] ? '0 : x;
`else
    load_fn = x;
`endif
  endfunction

  assign addr_sum    = base_q + ADDR_W'(idx_q);
  assign mem_addr    = addr_sum & ADDR_MASK;
  assign load_en     = !valid_q || out_ready;
  assign is_last_idx = (idx_q == (cnt_q - 9'd1));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    zwait_d = zwait_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base_addr;
          cnt_d  = word_count;
          idx_d  = '0;
          // A zero-length request spends one extra cycle in DONE so done lands at E1
          if (word_count == 9'd0) begin
            state_d = DONE;
            zwait_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (load_en) begin
          data_d  = load_fn(mem_rdata);
          valid_d = 1'b1;
          last_d  = is_last_idx;
          idx_d   = idx_q + 9'd1;
          if (is_last_idx) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (zwait_q) zwait_d = 1'b0;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      zwait_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      zwait_q <= zwait_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign done      = (state_q == DONE) && !zwait_q;

endmodule
